// File: rtl/ifu.sv
// rtl/ifu.sv - instruction fetch unit: single-outstanding fetch FSM feeding a fall-through instruction FIFO
module ifu #(
    parameter int              XLEN         = 32,
    parameter int              ILEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'('h80000000),
    parameter int              DEPTH        = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic                       imem_req_valid,
    input  logic                       imem_req_ready,
    output logic [XLEN-1:0]            imem_req_addr,
    input  logic                       imem_rsp_valid,
    input  logic [ILEN-1:0]            imem_rsp_data,
    input  logic                       imem_rsp_err,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       inst_valid,
    input  logic                       inst_ready,
    output logic [ILEN-1:0]            inst,
    output logic [XLEN-1:0]            inst_pc,
    output logic                       inst_err,
    output logic [$clog2(DEPTH+1)-1:0] buf_count
);
    localparam int              CW         = $clog2(DEPTH + 1);
    localparam int              AW         = $clog2(DEPTH);
    localparam int              STEP       = ILEN / 8;
    localparam logic [XLEN-1:0] STEP_V     = XLEN'(STEP);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(STEP - 1);
    localparam logic [CW-1:0]   FULL       = CW'(DEPTH);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

    state_t          state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] inflight_pc;
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic [ILEN-1:0] mem_inst [DEPTH];
    logic [XLEN-1:0] mem_pc   [DEPTH];
    logic            mem_err  [DEPTH];

    logic req_fire;
    logic push;
    logic pop;

    // A request is only offered when a buffer slot is guaranteed for its response
    assign imem_req_valid = rst_n && (state == S_REQ) && (buf_count < FULL);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign push           = (state == S_WAIT) && imem_rsp_valid && !redirect_valid;

    assign inst_valid = (buf_count != '0);
    assign pop        = inst_valid && inst_ready && !redirect_valid;
    assign inst       = inst_valid ? mem_inst[head] : '0;
    assign inst_pc    = inst_valid ? mem_pc[head]   : '0;
    assign inst_err   = inst_valid ? mem_err[head]  : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_REQ;
            fetch_pc    <= RESET_VECTOR;
            inflight_pc <= '0;
            head        <= '0;
            tail        <= '0;
            buf_count   <= '0;
        end else if (redirect_valid) begin
            fetch_pc  <= redirect_pc & ALIGN_MASK;
            head      <= '0;
            tail      <= '0;
            buf_count <= '0;
            // Any request still in flight after this edge must be swallowed in DROP
            case (state)
                S_REQ:   state <= req_fire ? S_DROP : S_REQ;
                S_WAIT:  state <= imem_rsp_valid ? S_REQ : S_DROP;
                S_DROP:  state <= imem_rsp_valid ? S_REQ : S_DROP;
                default: state <= S_REQ;
            endcase
        end else begin
            case (state)
                S_REQ: begin
                    if (req_fire) begin
                        inflight_pc <= fetch_pc;
                        fetch_pc    <= fetch_pc + STEP_V;
                        state       <= S_WAIT;
                    end
                end
                S_WAIT, S_DROP: begin
                    if (imem_rsp_valid) state <= S_REQ;
                end
                default: state <= S_REQ;
            endcase
            if (push) tail <= tail + AW'(1);
            if (pop)  head <= head + AW'(1);
            if (push && !pop)      buf_count <= buf_count + CW'(1);
            else if (pop && !push) buf_count <= buf_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_inst[tail] <= imem_rsp_data;
            mem_pc[tail]   <= inflight_pc;
            mem_err[tail]  <= imem_rsp_err;
        end
    end
endmodule

// File: tb/tb_ifu.sv
// tb/tb_ifu.sv - scoreboard bench for ifu with a latency-programmable instruction memory model
module tb_ifu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        imem_rsp_err = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_err;
    logic [1:0]  buf_count;

    ifu dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .inst_err(inst_err), .buf_count(buf_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        err;
    } exp_t;

    int          nchk = 0;
    int          nfail = 0;
    exp_t        exp_inst[$];
    logic [31:0] exp_req[$];
    int          grant = 0;
    int          lat = 1;
    int          cnt = 0;
    bit          pending = 0;
    logic [31:0] paddr = '0;
    logic [31:0] err_addr = '1;

    assign imem_req_ready = (grant > 0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: the response data is the bitwise inverse of the address
    always @(posedge clk) begin
        logic        f;
        logic [31:0] a;
        f = imem_req_valid && imem_req_ready;
        a = imem_req_addr;
        if (f) begin
            if (exp_req.size() == 0) begin
                nchk++;
                nfail++;
                $display("FAIL req_unexpected: got %h expected none", a);
            end else begin
                check("req_addr", a, exp_req.pop_front());
            end
        end
        #1;
        imem_rsp_valid = 1'b0;
        if (f) begin
            grant   = grant - 1;
            pending = 1;
            paddr   = a;
            cnt     = lat;
        end
        if (pending) begin
            if (cnt <= 1) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = ~paddr;
                imem_rsp_err   = (paddr == err_addr);
                pending        = 0;
            end else begin
                cnt = cnt - 1;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && inst_valid && inst_ready && !redirect_valid) begin
            if (exp_inst.size() == 0) begin
                nchk++;
                nfail++;
                $display("FAIL inst_unexpected: got pc %h expected none", inst_pc);
            end else begin
                e = exp_inst.pop_front();
                check("inst_pc", inst_pc, e.pc);
                check("inst", inst, e.ins);
                check("inst_err", 32'(inst_err), 32'(e.err));
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("first_req_valid", 32'(imem_req_valid), 32'd1);
        check("first_req_addr", imem_req_addr, 32'h80000000);
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        pending        = 0;
        grant          = 0;
        lat            = 1;
        err_addr       = '1;
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        step(2);
        release_reset();
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_inst.size() != 0 || exp_req.size() != 0) && t < 100) begin
            step();
            t++;
        end
        nchk++;
        if (exp_inst.size() != 0 || exp_req.size() != 0) begin
            nfail++;
            $display("FAIL drain: got %0d insts %0d reqs outstanding expected 0", exp_inst.size(), exp_req.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        step(2);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_buf_count", 32'(buf_count), 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
        check("rst_inst_err", 32'(inst_err), 32'd0);

        // Sequential fetch with a consumer that never stalls
        do_reset();
        grant = 3;
        inst_ready = 1'b1;
        exp_req = '{32'h80000000, 32'h80000004, 32'h80000008};
        exp_inst.push_back('{32'h80000000, 32'h7FFFFFFF, 1'b0});
        exp_inst.push_back('{32'h80000004, 32'h7FFFFFFB, 1'b0});
        exp_inst.push_back('{32'h80000008, 32'h7FFFFFF7, 1'b0});
        drain();
        check("seq_buf_empty", 32'(buf_count), 32'd0);

        // Backpressure fills the buffer and stops requests
        do_reset();
        grant = 2;
        exp_req = '{32'h80000000, 32'h80000004};
        exp_inst.push_back('{32'h80000000, 32'h7FFFFFFF, 1'b0});
        exp_inst.push_back('{32'h80000004, 32'h7FFFFFFB, 1'b0});
        exp_inst.push_back('{32'h80000008, 32'h7FFFFFF7, 1'b0});
        step(8);
        check("full_buf_count", 32'(buf_count), 32'd2);
        check("full_req_valid", 32'(imem_req_valid), 32'd0);
        inst_ready = 1'b1;
        grant = 1;
        exp_req.push_back(32'h80000008);
        step();
        inst_ready = 1'b0;
        check("one_pop_count", 32'(buf_count), 32'd1);
        check("refill_req_valid", 32'(imem_req_valid), 32'd1);
        check("refill_req_addr", imem_req_addr, 32'h80000008);
        inst_ready = 1'b1;
        drain();

        // Redirect while waiting: the late response is discarded
        do_reset();
        lat = 3;
        grant = 1;
        inst_ready = 1'b1;
        exp_req = '{32'h80000000};
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h80001002;
        grant = 1;
        exp_req.push_back(32'h80001000);
        exp_inst.push_back('{32'h80001000, 32'h7FFFEFFF, 1'b0});
        step();
        redirect_valid = 1'b0;
        check("wait_redir_count", 32'(buf_count), 32'd0);
        check("wait_redir_drop", 32'(imem_req_valid), 32'd0);
        drain();

        // Redirect coinciding with a request handshake and a pop
        do_reset();
        grant = 1;
        exp_req = '{32'h80000000};
        step(2);
        check("pre_redir_count", 32'(buf_count), 32'd1);
        check("pre_redir_valid", 32'(imem_req_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h80002000;
        inst_ready = 1'b1;
        grant = 1;
        exp_req.push_back(32'h80000004);
        exp_req.push_back(32'h80002000);
        exp_inst.push_back('{32'h80002000, 32'h7FFFDFFF, 1'b0});
        step();
        redirect_valid = 1'b0;
        grant = 1;
        check("flush_count", 32'(buf_count), 32'd0);
        check("flush_inst_valid", 32'(inst_valid), 32'd0);
        check("drop_req_valid", 32'(imem_req_valid), 32'd0);
        drain();

        // Access fault on the second fetch
        do_reset();
        grant = 3;
        inst_ready = 1'b1;
        err_addr = 32'h80000004;
        exp_req = '{32'h80000000, 32'h80000004, 32'h80000008};
        exp_inst.push_back('{32'h80000000, 32'h7FFFFFFF, 1'b0});
        exp_inst.push_back('{32'h80000004, 32'h7FFFFFFB, 1'b1});
        exp_inst.push_back('{32'h80000008, 32'h7FFFFFF7, 1'b0});
        drain();

        // Asynchronous reset in WAIT with one buffered instruction
        do_reset();
        grant = 2;
        exp_req = '{32'h80000000, 32'h80000004};
        step(3);
        check("midwait_count", 32'(buf_count), 32'd1);
        check("midwait_req_valid", 32'(imem_req_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        check("async_req_valid", 32'(imem_req_valid), 32'd0);
        check("async_inst_valid", 32'(inst_valid), 32'd0);
        check("async_buf_count", 32'(buf_count), 32'd0);
        check("async_inst", inst, 32'd0);
        check("async_inst_pc", inst_pc, 32'd0);
        check("async_inst_err", 32'(inst_err), 32'd0);
        pending = 0;
        grant = 0;
        step(2);
        release_reset();
        grant = 1;
        inst_ready = 1'b1;
        exp_req.push_back(32'h80000000);
        exp_inst.push_back('{32'h80000000, 32'h7FFFFFFF, 1'b0});
        drain();

        $display("[TB] %0d tests run, %0d failed", nchk, nfail);
        $finish;
    end
endmodule

// File: doc/ifu.md
IFU -- requirements
Module: ifu

Interface
REQ-001 SHALL have parameter XLEN, default 32, address/PC width.
REQ-002 SHALL have parameter ILEN, default 32, instruction width; PC step is ILEN/8 bytes.
REQ-003 SHALL have parameter RESET_VECTOR, default XLEN'h80000000, first fetch address.
REQ-004 SHALL have parameter DEPTH, default 2, instruction buffer entries; legal values are a power of 2 and at least 2.
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port imem_req_valid, output, 1, fetch request valid.
REQ-008 SHALL have port imem_req_ready, input, 1, memory accepts the request.
REQ-009 SHALL have port imem_req_addr, output, XLEN, fetch address.
REQ-010 SHALL have port imem_rsp_valid, input, 1, response valid; always accepted, no backpressure.
REQ-011 SHALL have port imem_rsp_data, input, ILEN, fetched instruction.
REQ-012 SHALL have port imem_rsp_err, input, 1, access fault for this response.
REQ-013 SHALL have port redirect_valid, input, 1, branch/jump/trap redirect.
REQ-014 SHALL have port redirect_pc, input, XLEN, redirect target.
REQ-015 SHALL have port inst_valid, output, 1, buffer head valid to the IDU.
REQ-016 SHALL have port inst_ready, input, 1, IDU consumes the head.
REQ-017 SHALL have port inst, output, ILEN, head instruction.
REQ-018 SHALL have port inst_pc, output, XLEN, PC of the head instruction.
REQ-019 SHALL have port inst_err, output, 1, fault flag of the head instruction.
REQ-020 SHALL have port buf_count, output, $clog2(DEPTH+1), occupied entries.

Function
REQ-021 SHALL implement a three-state FSM: REQ (may issue), WAIT (one request outstanding), DROP (outstanding response to be discarded).
REQ-022 SHALL hold at most one outstanding request.
REQ-023 SHALL assert imem_req_valid only when state is REQ and buf_count < DEPTH; it depends on registered state only.
REQ-024 SHALL drive imem_req_addr from the fetch_pc register.
REQ-025 SHALL, on a request handshake (valid and ready), do all of: latch fetch_pc as the in-flight PC, advance fetch_pc by ILEN/8 with XLEN wrap-around, and go to WAIT.
REQ-026 SHALL, in WAIT on imem_rsp_valid, push {rsp_data, rsp_err, in-flight PC} into the buffer and go to REQ.
REQ-027 SHALL ignore imem_rsp_valid in REQ state.
REQ-028 SHALL, in DROP on imem_rsp_valid, discard the response and go to REQ.
REQ-029 SHALL operate the buffer as a FIFO with first-word fall-through: inst_valid = (buf_count != 0); inst/inst_pc/inst_err show the head combinationally.
REQ-030 SHALL pop the head on inst_valid and inst_ready.
REQ-031 SHALL leave buf_count unchanged on a simultaneous push and pop; the buffer never overflows, because REQ-023 reserves space.
REQ-032 SHALL, on redirect_valid, flush the buffer (buf_count = 0 next cycle).
REQ-033 SHALL, on redirect_valid, load fetch_pc with redirect_pc with its low $clog2(ILEN/8) bits cleared.
REQ-034 SHALL, on redirect_valid, select the next state as: WAIT without rsp -> DROP; WAIT with rsp -> REQ, rsp dropped; REQ with handshake in the same cycle -> DROP; REQ without handshake -> REQ; DROP without rsp -> DROP; DROP with rsp -> REQ.
REQ-035 SHALL give redirect priority over same-cycle push, pop and PC increment.
REQ-036 SHALL pass faulted responses through with inst_err = 1 and continue fetching sequentially.

Reset
REQ-037 SHALL, while rst_n = 0, set state = REQ, fetch_pc = RESET_VECTOR, buf_count = 0, imem_req_valid = 0, inst_valid = 0, and inst/inst_pc/inst_err = 0.
REQ-038 SHALL abandon any outstanding request on reset; a response arriving after reset release without a post-reset request is ignored.
REQ-039 SHALL assert imem_req_valid with addr RESET_VECTOR in the first cycle after rst_n rises.

Verification
REQ-040 SHALL cover this case: release reset, with ready = 1, 1-cycle response latency and inst_ready = 1 -> requests 0x80000000, 0x80000004, 0x80000008; inst_pc follows in order.
REQ-041 SHALL cover this case: inst_ready = 0, DEPTH = 2 -> after 2 responses buf_count = 2 and imem_req_valid = 0; raising inst_ready for one cycle -> a new request at 0x80000008.
REQ-042 SHALL cover this case: redirect_pc = 0x80001002 while in WAIT -> the following response is discarded, the next request is at 0x80001000, and buf_count = 0 in the cycle after the redirect.
REQ-043 SHALL cover this case: redirect in the same cycle as a request handshake and an inst pop -> state DROP, the buffer is flushed, and the first instruction delivered has inst_pc = the redirect target.
REQ-044 SHALL cover this case: rsp_err = 1 on the 2nd fetch -> inst_err = 1 only for inst_pc 0x80000004, and fetch continues at 0x80000008.
REQ-045 SHALL cover this case: assert rst_n = 0 mid-WAIT with buf_count = 1 -> all outputs go to their reset values immediately (asynchronously), and the first request after release is at 0x80000000.
